// File: rtl/chan_bin_table_loader.sv
// chan_bin_table_loader
//   Turns a 32-bit software register word (user_clk domain) into writes of a
//   double-buffered channel->FFT-bin table. The selector always reads the
//   active bank. Software writes land in the shadow bank. A requested bank swap
//   is committed only on a frame sync pulse, so the table never changes in the
//   middle of a frame.
// Ports
//   user_clk      fabric clock, rising edge
//   user_rst_n    asynchronous active-low reset
//   reg_data      [31] write toggle, [30] swap toggle, [29:20] addr,
//                 [19:12] reserved, [11:0] bin
//   sync_in       one-cycle frame-start pulse
//   rd_addr       selector read address
//   rd_bin        active-bank entry at rd_addr, one cycle of latency (0 if out of range)
//   active_bank   bank currently served to readers
//   swap_pending  swap requested, waiting for sync_in
//   wr_count      accepted writes, wraps
//   err_count     dropped or illegal requests, saturates at 255
module chan_bin_table_loader #(
  parameter int TABLE_DEPTH   = 1024,
  parameter int ADDR_W        = 10,
  parameter int BIN_W         = 12,
  parameter int STABLE_CYCLES = 2
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       reg_data,
  input  logic              sync_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BIN_W-1:0]  rd_bin,
  output logic              active_bank,
  output logic              swap_pending,
  output logic [15:0]       wr_count,
  output logic [7:0]        err_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(TABLE_DEPTH);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_r;
  logic [31:0]       reg_d_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              wr_tog_r;
  logic              sw_tog_r;

  logic [BIN_W-1:0]  bank_mem [2][TABLE_DEPTH];

  logic              stable_s;
  logic              wr_req_s;
  logic              sw_req_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [BIN_W-1:0]  wr_bin_s;
  logic              addr_ok_s;
  logic              rd_ok_s;
  logic              we_s;
  logic [1:0]        err_inc_s;
  logic [8:0]        err_sum_s;
  logic [7:0]        err_next_s;

  // Stabiliser: count consecutive identical samples of the software word.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      reg_d_r <= 32'd0;
      cnt_r   <= '0;
    end else begin
      reg_d_r <= reg_data;
      if (reg_data != reg_d_r) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Request decode from the stable sample.
  always_comb begin
    stable_s   = (cnt_r == CNT_MAX);
    wr_addr_s  = reg_d_r[20 +: ADDR_W];
    wr_bin_s   = reg_d_r[BIN_W-1:0];
    wr_req_s   = 1'b0;
    sw_req_s   = 1'b0;
    if ((state_r == S_RUN) && stable_s) begin
      wr_req_s = (reg_d_r[31] != wr_tog_r);
      sw_req_s = (reg_d_r[30] != sw_tog_r);
    end else begin
      wr_req_s = 1'b0;
      sw_req_s = 1'b0;
    end
    addr_ok_s  = ({1'b0, wr_addr_s} < DEPTH_L);
    rd_ok_s    = ({1'b0, rd_addr} < DEPTH_L);
    we_s       = wr_req_s && addr_ok_s;
    // A bad address and a dropped swap in the same sample count as two errors.
    err_inc_s  = {1'b0, wr_req_s && !addr_ok_s} + {1'b0, sw_req_s && swap_pending};
    err_sum_s  = {1'b0, err_count} + {7'd0, err_inc_s};
    err_next_s = err_sum_s[8] ? 8'hFF : err_sum_s[7:0];
  end

  // Control FSM, toggle tracking, bank selection and counters.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_r      <= S_INIT;
      wr_tog_r     <= 1'b0;
      sw_tog_r     <= 1'b0;
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
      wr_count     <= 16'd0;
      err_count    <= 8'd0;
    end else begin
      case (state_r)
        S_INIT: begin
          // Adopt whatever toggles software left behind; no action is issued.
          if (stable_s) begin
            wr_tog_r <= reg_d_r[31];
            sw_tog_r <= reg_d_r[30];
            state_r  <= S_RUN;
          end else begin
            state_r  <= S_INIT;
          end
        end
        S_RUN: begin
          if (wr_req_s) begin
            wr_tog_r <= reg_d_r[31];
          end else begin
            wr_tog_r <= wr_tog_r;
          end
          if (sw_req_s) begin
            sw_tog_r <= reg_d_r[30];
          end else begin
            sw_tog_r <= sw_tog_r;
          end
        end
        default: begin
          state_r <= S_INIT;
        end
      endcase

      // Commit uses the pending flag from before this edge, so a request seen
      // together with sync_in waits for the next pulse.
      if (sync_in && swap_pending) begin
        active_bank  <= ~active_bank;
        swap_pending <= 1'b0;
      end else if (sw_req_s && !swap_pending) begin
        swap_pending <= 1'b1;
      end else begin
        swap_pending <= swap_pending;
      end

      wr_count  <= wr_count + {15'd0, we_s};
      err_count <= err_next_s;
    end
  end

  // Table storage: writes always target the bank not being served.
  always_ff @(posedge user_clk) begin
    if (we_s) begin
      bank_mem[~active_bank][wr_addr_s] <= wr_bin_s;
    end
  end

  // Registered read of the active bank.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      rd_bin <= '0;
    end else if (rd_ok_s) begin
      rd_bin <= bank_mem[active_bank][rd_addr];
    end else begin
      rd_bin <= '0;
    end
  end

endmodule

// File: tb/tb_chan_bin_table_loader.sv
// Testbench for chan_bin_table_loader, built with a 550-entry table.
module tb_chan_bin_table_loader;

  localparam int DEPTH = 550;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] reg_data;
  logic        sync_in;
  logic [9:0]  rd_addr;
  logic [11:0] rd_bin;
  logic        active_bank;
  logic        swap_pending;
  logic [15:0] wr_count;
  logic [7:0]  err_count;

  chan_bin_table_loader #(
    .TABLE_DEPTH(DEPTH), .ADDR_W(10), .BIN_W(12), .STABLE_CYCLES(2)
  ) dut (
    .user_clk(clk), .user_rst_n(rst_n), .reg_data(reg_data), .sync_in(sync_in),
    .rd_addr(rd_addr), .rd_bin(rd_bin), .active_bank(active_bank),
    .swap_pending(swap_pending), .wr_count(wr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: two banks as plain arrays plus counters.
  logic [11:0] m_mem [2][1024];
  bit          m_ok  [2][1024];
  bit          m_act, m_pend, m_wt, m_st;
  int          m_wr, m_err;
  int          written_q[$];

  logic [12:0] exp_q[$];   // {care, value}
  bit          rd_issue = 1'b0;
  bit          issued_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_wr_count"}, 32'(wr_count), m_wr & 32'hFFFF);
    chk({tag, "_err_count"}, 32'(err_count), 32'(m_err));
    chk({tag, "_active"}, 32'(active_bank), 32'(m_act));
    chk({tag, "_pending"}, 32'(swap_pending), 32'(m_pend));
  endtask

  function automatic void m_write(input logic [9:0] a, input logic [11:0] b);
    if (int'(a) < DEPTH) begin
      m_mem[!m_act][a] = b;
      m_ok[!m_act][a]  = 1'b1;
      m_wr++;
      written_q.push_back(int'(a));
    end else begin
      m_err = (m_err >= 255) ? 255 : m_err + 1;
    end
  endfunction

  function automatic void m_swap();
    if (m_pend) m_err = (m_err >= 255) ? 255 : m_err + 1;
    else m_pend = 1'b1;
  endfunction

  function automatic void m_sync();
    if (m_pend) begin
      m_act  = !m_act;
      m_pend = 1'b0;
    end
  endfunction

  function automatic logic [12:0] expect_rd(input logic [9:0] a);
    if (int'(a) >= DEPTH) return {1'b1, 12'd0};
    if (m_ok[m_act][a]) return {1'b1, m_mem[m_act][a]};
    return 13'd0;
  endfunction

  function automatic logic [31:0] word(input logic [9:0] a, input logic [11:0] b);
    logic [7:0] rsv;
    rsv = 8'($urandom);
    return {m_wt, m_st, a, rsv, b};
  endfunction

  // One software transaction: flip toggles, hold the word long enough to act.
  task automatic txn(input bit do_w, input bit do_s, input logic [9:0] a, input logic [11:0] b);
    @(negedge clk);
    if (do_w) m_wt = !m_wt;
    if (do_s) m_st = !m_st;
    reg_data = word(a, b);
    if (do_w) m_write(a, b);
    if (do_s) m_swap();
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    sync_in = 1'b1;
    m_sync();
    @(negedge clk);
    sync_in = 1'b0;
  endtask

  function automatic logic [9:0] pick_addr();
    if (written_q.size() > 0 && $urandom_range(1, 0) == 1)
      return 10'(written_q[$urandom_range(written_q.size() - 1, 0)]);
    return 10'($urandom_range(1023, 0));
  endfunction

  task automatic reads(input int n);
    logic [9:0] a;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a = pick_addr();
      rd_addr = a;
      exp_q.push_back(expect_rd(a));
      rd_issue = 1'b1;
    end
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  // Reads straddling a sync pulse: the edge carrying sync still sees the old bank.
  task automatic sync_reads(input logic [9:0] a);
    @(negedge clk);
    sync_in = 1'b1;
    rd_addr = a;
    exp_q.push_back(expect_rd(a));
    rd_issue = 1'b1;
    m_sync();
    @(negedge clk);
    sync_in = 1'b0;
    exp_q.push_back(expect_rd(a));
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  // Scoreboard monitor: one expected entry per issued read, one cycle later.
  always @(posedge clk) issued_d <= rd_issue;

  always @(negedge clk) begin
    logic [12:0] e;
    if (issued_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_underflow actual=%0h expected=none", rd_bin);
      end else begin
        e = exp_q.pop_front();
        if (e[12]) chk("rd_bin", 32'(rd_bin), 32'(e[11:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    logic [9:0]  ra;
    int          r;

    rst_n = 1'b0; reg_data = 32'hC000_0000; sync_in = 1'b0; rd_addr = 10'd0;
    m_wt = 1'b1; m_st = 1'b1; m_act = 1'b0; m_pend = 1'b0; m_wr = 0; m_err = 0;

    // Reset state, then a nonzero register at reset exit does nothing.
    repeat (3) @(negedge clk);
    chk("rst_rd_bin", 32'(rd_bin), 32'd0);
    chk_state("rst");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_state("init");

    // Write latency: accepted on edge 3 after the change, not before.
    m_wt = 1'b0;
    reg_data = {m_wt, m_st, 10'd5, 8'h00, 12'h123};
    repeat (3) @(posedge clk);
    #1 chk("wr_lat_edge2", 32'(wr_count), 32'd0);
    @(posedge clk);
    #1 chk("wr_lat_edge3", 32'(wr_count), 32'd1);
    m_write(10'd5, 12'h123);
    txn(1'b0, 1'b1, 10'd5, 12'h000);
    chk_state("t2_req");
    pulse_sync();
    chk_state("t2_sync");
    @(negedge clk);
    rd_addr = 10'd5; exp_q.push_back({1'b1, 12'h123}); rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;

    // One-cycle glitches of either toggle are ignored.
    @(negedge clk);
    saved = reg_data;
    reg_data = saved ^ 32'h8000_0000;
    @(negedge clk);
    reg_data = saved;
    @(negedge clk);
    reg_data = saved ^ 32'h4000_0000;
    @(negedge clk);
    reg_data = saved;
    repeat (6) @(negedge clk);
    chk_state("glitch");

    // Swap request in the same cycle as sync_in is not committed by it.
    m_st = !m_st;
    reg_data = word(10'd0, 12'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    sync_in = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
    m_swap();
    chk_state("t5_same");
    txn(1'b0, 1'b1, 10'd0, 12'd0);
    chk_state("t5_drop");
    sync_reads(10'd5);
    chk_state("t5_commit");

    // Reset just before a stabilised write would land: write abandoned.
    txn(1'b1, 1'b0, 10'd7, 12'h555);
    chk_state("t6_pre");
    @(negedge clk);
    m_wt = !m_wt;
    reg_data = {m_wt, m_st, 10'd7, 8'h00, 12'h0AB};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    m_act = 1'b0; m_pend = 1'b0; m_wr = 0; m_err = 0;
    #1;
    chk("t6_rd_bin", 32'(rd_bin), 32'd0);
    chk_state("t6_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_state("t6_post");
    txn(1'b0, 1'b1, 10'd0, 12'd0);
    sync_reads(10'd7);
    chk_state("t6_swap");

    // Randomised traffic.
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(9, 0);
      if (r <= 3) begin
        if ($urandom_range(3, 0) == 0) ra = 10'($urandom_range(1023, DEPTH));
        else ra = 10'($urandom_range(DEPTH - 1, 0));
        txn(1'b1, 1'b0, ra, 12'($urandom));
      end else if (r == 4) begin
        txn(1'b1, 1'b1, 10'($urandom_range(1023, 0)), 12'($urandom));
      end else if (r <= 6) begin
        txn(1'b0, 1'b1, 10'd0, 12'd0);
      end else if (r == 7) begin
        sync_reads(pick_addr());
      end else begin
        reads(4);
      end
      chk_state("rand");
    end

    // Illegal address writes saturate the error counter.
    for (int n = 0; n < 256; n++) txn(1'b1, 1'b0, 10'd1023, 12'($urandom));
    chk("sat_err", 32'(err_count), 32'd255);
    chk_state("sat");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
